// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, used by vga_sync and by the
// frame-border, paddle and ball drawing blocks.
package vga_pkg;
    localparam int COUNT_W   = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Sync windows are half-open: [START, END)
    localparam int HS_START  = H_VISIBLE + H_FRONT;
    localparam int HS_END    = HS_START + H_SYNC;
    localparam int VS_START  = V_VISIBLE + V_FRONT;
    localparam int VS_END    = VS_START + V_SYNC;
endpackage

// File: rtl/pixel_tick_gen.sv
// Clock divider: p_tick is high for one clk in every CLK_DIV clks.
// Also usable as a generic rate enable (e.g. ball-speed timing).
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             div_last;

    assign div_last = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_last) div_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) div_cnt_q <= '0;
        else       div_cnt_q <= div_cnt_d;
    end

    // Gated by reset so nothing downstream advances while held in reset
    assign p_tick = div_last && !reset;
endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: pixel/line counters with registered sync and
// video_on decoded from the next-state counts so they align with hcount/vcount.
module vga_sync
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COUNT_W-1:0] hcount,
    output logic [COUNT_W-1:0] vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic               frame_tick
);
    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOT - 1);
    localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOT - 1);
    localparam logic [COUNT_W-1:0] H_VIS  = COUNT_W'(H_VISIBLE);
    localparam logic [COUNT_W-1:0] V_VIS  = COUNT_W'(V_VISIBLE);
    localparam logic [COUNT_W-1:0] HS_LO  = COUNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [COUNT_W-1:0] HS_HI  = COUNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COUNT_W-1:0] VS_LO  = COUNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [COUNT_W-1:0] VS_HI  = COUNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [COUNT_W-1:0] hcount_q, hcount_d;
    logic [COUNT_W-1:0] vcount_q, vcount_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               video_on_q, video_on_d;
    logic               h_wrap, v_wrap;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    assign h_wrap = (hcount_q == H_LAST);
    assign v_wrap = (vcount_q == V_LAST);

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (p_tick) begin
            hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
            if (h_wrap) vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
        end
        // Decode from next-state counts so outputs line up with the counts
        hsync_d    = !((hcount_d >= HS_LO) && (hcount_d < HS_HI));
        vsync_d    = !((vcount_d >= VS_LO) && (vcount_d < VS_HI));
        video_on_d = (hcount_d < H_VIS) && (vcount_d < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q   <= '0;
            vcount_q   <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
        end else begin
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign hcount     = hcount_q;
    assign vcount     = vcount_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign frame_tick = p_tick && h_wrap && v_wrap;
endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync using a scaled-down raster so full
// frames are short; expected outputs come from an elapsed-clock model.
module tb_vga_sync;
    localparam int CD = 2;
    localparam int HV = 16, HF = 4, HSW = 6, HB = 6;
    localparam int VV = 8,  VF = 2, VSW = 2, VB = 4;
    localparam int HT = HV + HF + HSW + HB;   // 32
    localparam int VT = VV + VF + VSW + VB;   // 16
    localparam int FRAME_CLKS = HT * VT * CD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hcount, vcount;
    logic       hsync, vsync, video_on, p_tick, frame_tick;

    int checks = 0;
    int errors = 0;

    // Model state: clk edges with reset low since the last reset edge
    int m = 0;
    bit in_rst = 1'b1;
    int cyc = 0;

    vga_sync #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .p_tick(p_tick), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m <= 0;
            in_rst <= 1'b1;
        end else begin
            m <= m + 1;
            in_rst <= 1'b0;
        end
    end

    // {hcount, vcount, hsync, vsync, video_on, p_tick, frame_tick}
    function automatic logic [24:0] model_vec();
        int pix, hc, vc;
        logic pt, hs, vs, von, ft;
        pix = m / CD;
        hc  = pix % HT;
        vc  = (pix / HT) % VT;
        pt  = !reset && ((m % CD) == CD - 1);
        hs  = !(hc >= HV + HF && hc < HV + HF + HSW);
        vs  = !(vc >= VV + VF && vc < VV + VF + VSW);
        von = !in_rst && hc < HV && vc < VV;
        ft  = pt && hc == HT - 1 && vc == VT - 1;
        return {hc[9:0], vc[9:0], hs, vs, von, pt, ft};
    endfunction

    function automatic logic [24:0] dut_vec();
        return {hcount, vcount, hsync, vsync, video_on, p_tick, frame_tick};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [24:0] exp_v;
        reset = 1'b1;
        exp_v = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_v) begin
                errors++;
                $display("FAIL reset cyc%0d got %h exp %h", i, dut_vec(), exp_v);
            end
        end
    endtask

    task automatic test_release();
        int exp_hc[6] = '{0, 1, 1, 2, 2, 3};
        logic exp_pt[6] = '{1, 0, 1, 0, 1, 0};
        reset = 1'b0;
        #1;
        checks++;
        if (hcount !== 10'd0 || p_tick !== 1'b0) begin
            errors++;
            $display("FAIL release_pre hcount=%0d p_tick=%b exp 0/0", hcount, p_tick);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (hcount !== 10'(exp_hc[i]) || p_tick !== exp_pt[i] || video_on !== 1'b1 ||
                hsync !== 1'b1 || vsync !== 1'b1) begin
                errors++;
                $display("FAIL release_seq%0d hc=%0d pt=%b von=%b hs=%b vs=%b exp hc=%0d pt=%b von=1 hs=1 vs=1",
                         i, hcount, p_tick, video_on, hsync, vsync, exp_hc[i], exp_pt[i]);
            end
        end
    endtask

    task automatic test_hsync();
        int low_ticks = 0;
        for (int i = 0; i < HT * CD; i++) begin
            step();
            if (p_tick && !hsync) low_ticks++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL hsync_model got %h exp %h", dut_vec(), model_vec());
            end
        end
        checks++;
        if (low_ticks != HSW) begin
            errors++;
            $display("FAIL hsync_width got %0d exp %0d", low_ticks, HSW);
        end
    endtask

    task automatic test_frame();
        int vlow = 0, nft = 0, t_first = -1, t_second = -1;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            step();
            if (p_tick && !vsync) vlow++;
            if (frame_tick) begin
                nft++;
                if (t_first < 0) t_first = cyc;
                else if (t_second < 0) t_second = cyc;
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL frame_model got %h exp %h", dut_vec(), model_vec());
            end
        end
        checks++;
        if (nft != 2 || (t_second - t_first) != FRAME_CLKS) begin
            errors++;
            $display("FAIL frame_period pulses=%0d period=%0d exp 2/%0d", nft, t_second - t_first, FRAME_CLKS);
        end
        checks++;
        if (vlow != 2 * VSW * HT) begin
            errors++;
            $display("FAIL vsync_width got %0d exp %0d", vlow, 2 * VSW * HT);
        end
    endtask

    task automatic test_video_on();
        int  ch[5] = '{HV - 1, HV, 0, 0, HT - 1};
        int  cv[5] = '{0, 0, VV - 1, VV, VT - 1};
        logic ce[5] = '{1, 0, 1, 0, 0};
        for (int k = 0; k < 5; k++) begin
            int n = 0;
            while (!(hcount == 10'(ch[k]) && vcount == 10'(cv[k])) && n < FRAME_CLKS + 8) begin
                step();
                n++;
            end
            checks++;
            if (n >= FRAME_CLKS + 8) begin
                errors++;
                $display("FAIL video_on_timeout (%0d,%0d) not reached", ch[k], cv[k]);
            end else if (video_on !== ce[k]) begin
                errors++;
                $display("FAIL video_on(%0d,%0d) got %b exp %b", ch[k], cv[k], video_on, ce[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        int hsel = HV + HF + 2;
        int vsel = VV + VF + 1;
        while (!(hcount == 10'(hsel) && vcount == 10'(vsel)) && n < FRAME_CLKS + 8) begin
            step();
            n++;
        end
        checks++;
        if (n >= FRAME_CLKS + 8 || hsync !== 1'b0 || vsync !== 1'b0) begin
            errors++;
            $display("FAIL midrst_setup n=%0d hs=%b vs=%b exp both 0", n, hsync, vsync);
        end
        reset = 1'b1;
        step();
        checks++;
        if (dut_vec() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_state got %h exp %h", dut_vec(), {10'd0, 10'd0, 5'b11000});
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL midrst_resume got %h exp %h", dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int run = $urandom_range(1, 400);
            int hold = $urandom_range(1, 4);
            reset = 1'b0;
            for (int i = 0; i < run; i++) begin
                step();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++;
                    $display("FAIL random_run it%0d got %h exp %h", it, dut_vec(), model_vec());
                end
            end
            reset = 1'b1;
            for (int i = 0; i < hold; i++) begin
                step();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++;
                    $display("FAIL random_rst it%0d got %h exp %h", it, dut_vec(), model_vec());
                end
            end
        end
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_release();
        test_hsync();
        test_frame();
        test_video_on();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
